// File: rtl/comp2_serial_sched.sv
// Bit-serial two's-complement negation shared by two requesters via round-robin.
// One invert-and-increment half-adder cell is reused for WIDTH clocks per operand.

module comp2_cell (
  input  logic a,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic b;
  assign b    = ~a;
  assign s    = b ^ cin;
  assign cout = b & cin;
endmodule

module comp2_serial_sched #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_ovf,
  output logic             res_src,
  input  logic             res_ready,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh;
  logic [CNT_W-1:0] cnt;
  logic             carry, msb_in, last_served, src_q;
  logic             gnt, any_req, accept, sum_bit, carry_nxt;

  comp2_cell u_cell (.a(sh[0]), .cin(carry), .s(sum_bit), .cout(carry_nxt));

  // Tie goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    any_req = req0_valid | req1_valid;
    gnt     = 1'b0;
    if (req0_valid && req1_valid) gnt = ~last_served;
    else                          gnt = req1_valid;
  end

  // Gated by rst_n so ready is low for the whole reset window, not just after.
  assign req0_ready = rst_n & (state == IDLE) & any_req & ~gnt;
  assign req1_ready = rst_n & (state == IDLE) & any_req &  gnt;
  assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (cnt == CNT_W'(WIDTH-1)) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sh          <= '0;
      cnt         <= '0;
      carry       <= 1'b0;
      msb_in      <= 1'b0;
      last_served <= 1'b1;
      src_q       <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          sh          <= gnt ? req1_data : req0_data;
          msb_in      <= gnt ? req1_data[WIDTH-1] : req0_data[WIDTH-1];
          carry       <= 1'b1;
          cnt         <= '0;
          src_q       <= gnt;
          last_served <= gnt;
        end
        RUN: begin
          sh    <= {sum_bit, sh[WIDTH-1:1]};
          carry <= carry_nxt;
          cnt   <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign res_valid = (state == DONE);
  assign res_data  = res_valid ? sh : '0;
  // Only the most-negative operand negates to itself.
  assign res_ovf   = res_valid & msb_in & sh[WIDTH-1] & ~|sh[WIDTH-2:0];
  assign res_src   = src_q;
  assign busy      = (state != IDLE);
endmodule

// File: tb/tb_comp2_serial_sched.sv
// Directed bench for comp2_serial_sched (WIDTH=6) with immediate assertions.
module tb_comp2_serial_sched;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_data, req1_data, res_data;
  logic         res_valid, res_ovf, res_src, res_ready, busy;

  int n_cmp = 0;
  int n_err = 0;

  comp2_serial_sched #(.WIDTH(W), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ovf(res_ovf),
    .res_src(res_src), .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Advance until res_valid, returning edges taken; bounded.
  task automatic wait_res(output int n);
    n = 0;
    while (res_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  // Full transaction from IDLE with res_ready=1.
  task automatic run_op(input string tag, input bit src, input logic [W-1:0] d,
                        input logic [W-1:0] exp, input bit exp_ovf);
    int n;
    if (src) begin req1_valid = 1'b1; req1_data = d; end
    else     begin req0_valid = 1'b1; req0_data = d; end
    #1;
    chk({tag, "_ready"}, src ? req1_ready : req0_ready, 1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_res(n);
    chk({tag, "_lat"}, n, W);
    chk({tag, "_data"}, res_data, exp);
    chk({tag, "_ovf"}, res_ovf, exp_ovf);
    chk({tag, "_src"}, res_src, src);
    tick();
    chk({tag, "_idle"}, {res_valid, busy}, 0);
  endtask

  initial begin
    int n;
    bit exp_src;
    rst_n = 1'b0; res_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = '0; req1_data = '0;
    #2;
    chk("rst_outs", {req0_ready, req1_ready, res_valid, busy, res_ovf, res_src}, 0);
    chk("rst_data", res_data, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Basic negation from req0
    run_op("r0a", 0, 6'b000001, 6'b111111, 0);
    run_op("r0b", 0, 6'b000011, 6'b111101, 0);
    run_op("r0c", 0, 6'b000111, 6'b111001, 0);

    // Boundary operands via req1
    run_op("zero", 1, 6'b000000, 6'b000000, 0);
    run_op("mneg", 1, 6'b100000, 6'b100000, 1);
    run_op("mpos", 1, 6'b011111, 6'b100001, 0);
    run_op("ones", 1, 6'b111111, 6'b000001, 0);

    // Round-robin with both continuously valid; req1 was served last
    req0_valid = 1'b1; req0_data = 6'b000010;
    req1_valid = 1'b1; req1_data = 6'b000100;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_src = i[0];
      chk("rr_onehot", {req0_ready, req1_ready}, exp_src ? 2'b01 : 2'b10);
      tick();
      n = 0;
      while (res_valid !== 1'b1 && n < 40) begin
        chk("rr_noready", {req0_ready, req1_ready}, 0);
        tick();
        n++;
      end
      chk("rr_lat", n, W);
      chk("rr_src", res_src, exp_src);
      chk("rr_data", res_data, exp_src ? 6'b111100 : 6'b111110);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Backpressure: hold result 10 cycles, req1 waiting throughout
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 6'b000101;
    #1;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 6'b001000;
    wait_res(n);
    chk("bp_lat", n, W);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold", {res_valid, res_src, res_data}, {1'b1, 1'b0, 6'b111011});
      chk("bp_noready", {req0_ready, req1_ready}, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("bp_drop", res_valid, 0);
    chk("bp_resume", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    res_ready = 1'b1;
    wait_res(n);
    chk("bp2_lat", n, W);
    chk("bp2_data", res_data, 6'b111000);
    chk("bp2_src", res_src, 1);
    tick();

    // Asynchronous reset on the third RUN cycle
    req1_valid = 1'b1; req1_data = 6'b000011;
    #1;
    tick();
    req1_valid = 1'b0;
    tick(); tick();
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outs", {req0_ready, req1_ready, res_valid, busy, res_ovf, res_src}, 0);
    chk("arst_data", res_data, 0);
    #3 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid === 1'b1) n++;
    end
    chk("arst_noresult", n, 0);
    req0_valid = 1'b1; req0_data = 6'b000110;
    req1_valid = 1'b1; req1_data = 6'b000001;
    #1;
    chk("arst_tie", {req0_ready, req1_ready}, 2'b10);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_res(n);
    chk("arst_lat", n, W);
    chk("arst_res", {res_src, res_data}, {1'b0, 6'b111010});
    tick();

    // Data changed right after accept must not matter
    req0_valid = 1'b1; req0_data = 6'b010101;
    #1;
    tick();
    req0_valid = 1'b0; req0_data = 6'b111111;
    wait_res(n);
    chk("late_lat", n, W);
    chk("late_data", res_data, 6'b101011);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
